// File: rtl/inst_fetch_encode.sv
// Byte-serial 6502-style instruction fetcher: pulls opcode and operand bytes
// over a single-outstanding read bus and presents one decoded packet at a time.
module inst_fetch_encode #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [7:0]  pkt_opcode,
    output logic [7:0]  pkt_op_lo,
    output logic [7:0]  pkt_op_hi,
    output logic [15:0] pkt_pc,
    output logic [1:0]  pkt_len,
    output logic        pkt_illegal
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH_OP = 3'd1;
    localparam logic [2:0] FETCH_LO = 3'd2;
    localparam logic [2:0] FETCH_HI = 3'd3;
    localparam logic [2:0] PRESENT  = 3'd4;
    localparam logic [2:0] DRAIN    = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_d;
    logic [15:0] pc;
    logic [15:0] pc_d;
    logic [15:0] drain_addr;
    logic        in_fetch;
    logic [1:0]  rdata_len;

    // Instruction length from the aaabbbcc opcode layout; cc=11 is unassigned.
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd2;
        if (op[1:0] == 2'b11) begin
            len = 2'd1;
        end else if (op[1:0] == 2'b01) begin
            if (op[4:2] == 3'b011 || op[4:2] == 3'b110 || op[4:2] == 3'b111)
                len = 2'd3;
            else
                len = 2'd2;
        end else begin
            case (op[4:2])
                3'b011, 3'b111: len = 2'd3;
                3'b010, 3'b110: len = 2'd1;
                3'b001, 3'b100, 3'b101: len = 2'd2;
                default: begin
                    if (op == 8'h20)
                        len = 2'd3;
                    else if (op == 8'h00 || op == 8'h40 || op == 8'h60)
                        len = 2'd1;
                    else
                        len = 2'd2;
                end
            endcase
        end
        return len;
    endfunction

    assign in_fetch  = (state == FETCH_OP) || (state == FETCH_LO) || (state == FETCH_HI);
    assign rdata_len = decode_len(mem_rdata);

    // DRAIN keeps presenting the abandoned address while pc already holds the redirect target.
    assign mem_req   = in_fetch || (state == DRAIN);
    assign mem_addr  = in_fetch ? pc : ((state == DRAIN) ? drain_addr : 16'h0000);
    assign pkt_valid = (state == PRESENT);

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (run)
                    state_d = FETCH_OP;
            end
            FETCH_OP: begin
                if (pc_load)
                    state_d = mem_ack ? FETCH_OP : DRAIN;
                else if (mem_ack)
                    state_d = (rdata_len == 2'd1) ? PRESENT : FETCH_LO;
            end
            FETCH_LO: begin
                if (pc_load)
                    state_d = mem_ack ? FETCH_OP : DRAIN;
                else if (mem_ack)
                    state_d = (pkt_len == 2'd2) ? PRESENT : FETCH_HI;
            end
            FETCH_HI: begin
                if (pc_load)
                    state_d = mem_ack ? FETCH_OP : DRAIN;
                else if (mem_ack)
                    state_d = PRESENT;
            end
            PRESENT: begin
                if (pc_load || pkt_ready)
                    state_d = run ? FETCH_OP : IDLE;
            end
            DRAIN: begin
                if (mem_ack)
                    state_d = FETCH_OP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc;
        if (pc_load)
            pc_d = pc_load_value;
        else if (in_fetch && mem_ack)
            pc_d = pc + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drain_addr  <= 16'h0000;
            pkt_opcode  <= 8'h00;
            pkt_op_lo   <= 8'h00;
            pkt_op_hi   <= 8'h00;
            pkt_pc      <= 16'h0000;
            pkt_len     <= 2'd0;
            pkt_illegal <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (in_fetch && pc_load)
                drain_addr <= pc;
            // A redirect in the ack cycle wins, so the returning byte is discarded.
            if (in_fetch && mem_ack && !pc_load) begin
                case (state)
                    FETCH_OP: begin
                        pkt_opcode  <= mem_rdata;
                        pkt_op_lo   <= 8'h00;
                        pkt_op_hi   <= 8'h00;
                        pkt_pc      <= pc;
                        pkt_len     <= rdata_len;
                        pkt_illegal <= (mem_rdata[1:0] == 2'b11);
                    end
                    FETCH_LO: pkt_op_lo <= mem_rdata;
                    FETCH_HI: pkt_op_hi <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_encode.sv
// Directed bench for inst_fetch_encode: a memory responder, a next-packet
// address model checked every cycle, and literal expectations per scenario.
module tb_inst_fetch_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_opcode;
    logic [7:0]  pkt_op_lo;
    logic [7:0]  pkt_op_hi;
    logic [15:0] pkt_pc;
    logic [1:0]  pkt_len;
    logic        pkt_illegal;

    logic [7:0]  mem [0:65535];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        manual_ack = 1'b0;
    logic [15:0] addr_log [$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] model_pc = 16'h8000;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_rst = 1'b1;
    logic [15:0] prev_addr = 16'h0000;

    inst_fetch_encode #(.RESET_PC(16'h8000)) dut (
        .clk(clk), .rst(rst), .run(run),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_opcode(pkt_opcode), .pkt_op_lo(pkt_op_lo), .pkt_op_hi(pkt_op_hi),
        .pkt_pc(pkt_pc), .pkt_len(pkt_len), .pkt_illegal(pkt_illegal)
    );

    always #5 clk = ~clk;

    function automatic int model_len(input logic [7:0] op);
        if (op[1:0] == 2'b11) return 1;
        if (op[1:0] == 2'b01) return (op[4:2] == 3'd3 || op[4:2] == 3'd6 || op[4:2] == 3'd7) ? 3 : 2;
        if (op[4:2] == 3'd3 || op[4:2] == 3'd7) return 3;
        if (op[4:2] == 3'd2 || op[4:2] == 3'd6) return 1;
        if (op[4:2] != 3'd0) return 2;
        if (op == 8'h20) return 3;
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
        return 2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic rdy);
        pc_load       = ld;
        pc_load_value = val;
        pkt_ready     = rdy;
        step();
        pc_load   = 1'b0;
        pkt_ready = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!pkt_valid && n < 200) begin
            step();
            n++;
        end
        checkOutput({tag, "_valid"}, pkt_valid, 1);
    endtask

    task automatic wait_addr(input string tag, input logic [15:0] addr);
        int n;
        n = 0;
        while (!(mem_req && mem_addr == addr) && n < 200) begin
            step();
            n++;
        end
        checkOutput({tag, "_addr"}, mem_addr, addr);
    endtask

    task automatic expect_packet(input string tag, input logic [7:0] op, input logic [7:0] lo,
                                 input logic [7:0] hi, input logic [15:0] pc,
                                 input logic [1:0] len, input logic ill);
        wait_valid(tag);
        checkOutput({tag, "_opcode"}, pkt_opcode, op);
        checkOutput({tag, "_op_lo"}, pkt_op_lo, lo);
        checkOutput({tag, "_op_hi"}, pkt_op_hi, hi);
        checkOutput({tag, "_pc"}, pkt_pc, pc);
        checkOutput({tag, "_len"}, pkt_len, len);
        checkOutput({tag, "_illegal"}, pkt_illegal, ill);
        applyStimulus(1'b0, 16'h0000, 1'b1);
    endtask

    // Memory responder: acks after ack_delay wait cycles, logs acked addresses.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req && wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                addr_log.push_back(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack   = manual_ack;
                mem_rdata = manual_ack ? mem[mem_addr] : 8'h00;
                if (mem_req) wait_cnt++;
                else wait_cnt = 0;
            end
        end
    end

    // Model: model_pc is where the next presented packet must start.
    initial begin
        int          len;
        logic [15:0] a1;
        logic [15:0] a2;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_pc = 16'h8000;
            end else begin
                if (prev_req && !prev_ack && !prev_rst) begin
                    checkOutput("req_hold", mem_req, 1);
                    checkOutput("addr_hold", mem_addr, prev_addr);
                end
                if (pkt_valid) begin
                    len = model_len(mem[model_pc]);
                    a1  = model_pc + 16'd1;
                    a2  = model_pc + 16'd2;
                    checkOutput("model_pc", pkt_pc, model_pc);
                    checkOutput("model_opcode", pkt_opcode, mem[model_pc]);
                    checkOutput("model_op_lo", pkt_op_lo, (len >= 2) ? mem[a1] : 8'h00);
                    checkOutput("model_op_hi", pkt_op_hi, (len == 3) ? mem[a2] : 8'h00);
                    checkOutput("model_len", pkt_len, len);
                    checkOutput("model_illegal", pkt_illegal, (mem[model_pc] & 8'h03) == 8'h03);
                    checkOutput("model_no_req", mem_req, 0);
                    if (!pc_load && pkt_ready)
                        model_pc = model_pc + 16'(len);
                end
                if (pc_load)
                    model_pc = pc_load_value;
            end
            prev_req  = mem_req;
            prev_ack  = mem_ack;
            prev_rst  = rst;
            prev_addr = mem_addr;
        end
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        pc_load = 1'b0;
        pc_load_value = 16'h0000;
        pkt_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h05;
        mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        mem[16'h0001] = 8'h20; mem[16'h0002] = 8'hCD; mem[16'h0003] = 8'hAB; mem[16'h0004] = 8'h60;
        mem[16'h0100] = 8'hA9; mem[16'h0101] = 8'h05;
        mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h90;

        repeat (3) step();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0000);
        checkOutput("rst_pkt_valid", pkt_valid, 0);
        checkOutput("rst_pkt_len", pkt_len, 0);
        checkOutput("rst_pkt_opcode", pkt_opcode, 0);
        checkOutput("rst_pkt_pc", pkt_pc, 0);
        rst = 1'b0;
        run = 1'b1;

        $display("[TB] LDA #5 at reset vector");
        expect_packet("lda", 8'hA9, 8'h05, 8'h00, 16'h8000, 2'd2, 1'b0);
        checkOutput("lda_log_n", addr_log.size(), 2);
        checkOutput("lda_log0", addr_log[0], 16'h8000);
        checkOutput("lda_log1", addr_log[1], 16'h8001);

        $display("[TB] backpressure on NOP");
        wait_valid("nop");
        repeat (5) begin
            checkOutput("bp_valid", pkt_valid, 1);
            checkOutput("bp_mem_req", mem_req, 0);
            checkOutput("bp_opcode", pkt_opcode, 8'hEA);
            checkOutput("bp_len", pkt_len, 2'd1);
            step();
        end
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("bp_next_req", mem_req, 1);
        checkOutput("bp_next_addr", mem_addr, 16'h8003);
        checkOutput("bp_valid_drop", pkt_valid, 0);

        $display("[TB] JMP across address wrap");
        wait_valid("pre_jmp");
        addr_log.delete();
        applyStimulus(1'b1, 16'hFFFE, 1'b1);
        checkOutput("jmp_discard", pkt_valid, 0);
        expect_packet("jmp", 8'h4C, 8'h34, 8'h12, 16'hFFFE, 2'd3, 1'b0);
        checkOutput("jmp_log_n", addr_log.size(), 3);
        checkOutput("jmp_log0", addr_log[0], 16'hFFFE);
        checkOutput("jmp_log1", addr_log[1], 16'hFFFF);
        checkOutput("jmp_log2", addr_log[2], 16'h0000);
        checkOutput("jmp_next_req", mem_req, 1);
        checkOutput("jmp_next_addr", mem_addr, 16'h0001);

        $display("[TB] illegal, JSR and RTS lengths");
        wait_valid("jsr0");
        checkOutput("jsr0_opcode", pkt_opcode, 8'h20);
        checkOutput("jsr0_len", pkt_len, 2'd3);
        mem[16'h0000] = 8'h03;
        applyStimulus(1'b1, 16'h0000, 1'b0);
        expect_packet("ill", 8'h03, 8'h00, 8'h00, 16'h0000, 2'd1, 1'b1);
        checkOutput("ill_next_addr", mem_addr, 16'h0001);
        expect_packet("jsr", 8'h20, 8'hCD, 8'hAB, 16'h0001, 2'd3, 1'b0);
        expect_packet("rts", 8'h60, 8'h00, 8'h00, 16'h0004, 2'd1, 1'b0);

        $display("[TB] redirect during operand fetch with late ack");
        wait_valid("pre_drain");
        ack_delay = 3;
        applyStimulus(1'b1, 16'h0100, 1'b0);
        wait_addr("drain_lo", 16'h0101);
        addr_log.delete();
        applyStimulus(1'b1, 16'hC000, 1'b0);
        for (int n = 0; n < 20 && mem_addr != 16'hC000; n++) begin
            checkOutput("drain_req", mem_req, 1);
            checkOutput("drain_valid", pkt_valid, 0);
            step();
        end
        checkOutput("drain_next_addr", mem_addr, 16'hC000);
        checkOutput("drain_log_n", addr_log.size(), 1);
        checkOutput("drain_log0", addr_log[0], 16'h0101);
        expect_packet("drain_pkt", 8'hEA, 8'h00, 8'h00, 16'hC000, 2'd1, 1'b0);

        $display("[TB] run drop mid-fetch");
        ack_delay = 2;
        run = 1'b0;
        expect_packet("runoff", 8'hEA, 8'h00, 8'h00, 16'hC001, 2'd1, 1'b0);
        repeat (4) begin
            checkOutput("idle_req", mem_req, 0);
            checkOutput("idle_valid", pkt_valid, 0);
            step();
        end

        $display("[TB] reset during FETCH_HI with late ack");
        applyStimulus(1'b1, 16'h0200, 1'b0);
        run = 1'b1;
        wait_addr("hi", 16'h0202);
        rst = 1'b1;
        step();
        rst = 1'b0;
        manual_ack = 1'b1;
        checkOutput("rsthi_req", mem_req, 0);
        checkOutput("rsthi_addr", mem_addr, 16'h0000);
        checkOutput("rsthi_valid", pkt_valid, 0);
        checkOutput("rsthi_len", pkt_len, 0);
        step();
        manual_ack = 1'b0;
        checkOutput("rsthi_restart_req", mem_req, 1);
        checkOutput("rsthi_restart_addr", mem_addr, 16'h8000);
        expect_packet("rsthi_pkt", 8'hA9, 8'h05, 8'h00, 16'h8000, 2'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
